// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, FSM state encoding and datapath select constants for multicycle_control.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_EXEC_I   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_e;
  function automatic state_e decode_target(input logic [5:0] op);
    return (op == OP_LW || op == OP_SW) ? S_MEM_ADDR :
           (op == OP_RTYPE)             ? S_EXEC_R   :
           (op == OP_BEQ)               ? S_BRANCH   :
           (op == OP_ADDI)              ? S_EXEC_I   :
           (op == OP_J)                 ? S_JUMP     : S_ILLEGAL;
  endfunction
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for a multicycle MIPS-subset datapath.
// Inputs: clk, rst_n (async, active-low), instr_op (IR[31:26]), mem_ready (memory handshake).
// Outputs: PC/memory/IR/regfile/ALU controls, debug state, instr_done pulse,
// illegal_op trap flag and a wrapping retired-instruction counter.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       instr_op,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CNT_W'(instr_done);
    end
  end
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_RT;
    alu_op        = ALU_OP_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH;
        state_d   = decode_target(instr_op);
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = (instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      // Unused encodings recover through a clean restart.
      default: state_d = S_RESET;
    endcase
  end
  assign state       = state_q;
  assign instr_count = count_q;
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multicycle MIPS-subset datapath: shared memory, IR, ALU, register file and PC.
- Decodes `instr_op` from the IR and drives per-cycle datapath controls. Supported opcodes: R-type, lw, sw, beq, addi, j.
- Stretches memory cycles on a `mem_ready` handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- instr_op  in  6  IR[31:26]; valid from DECODE until FETCH.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data: 0 ALUOut, 1 MDR.
- reg_dst  out  1  destination register: 0 rt, 1 rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A input: 0 PC, 1 rs.
- alu_src_b  out  2  ALU B input: 00 rt, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- alu_op  out  2  00 add, 01 sub, 10 decode funct.
- state  out  4  current state encoding, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  high while trapped.
- instr_count  out  CNT_W  retired instructions; wraps at 2^CNT_W.

Behaviour:
- Reset (async on rst_n low): state=S_RESET, instr_count=0. All outputs are 0 while in S_RESET. The next edge after release always goes to FETCH.
- Every output defaults to 0. Each state drives only the values listed below.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready (Mealy).
  - Holds in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE: drives alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 or 101011 -> MEM_ADDR
  - 000000 -> EXEC_R
  - 000100 -> BRANCH
  - 001000 -> EXEC_I
  - 000010 -> JUMP
  - any other value -> ILLEGAL
- MEM_ADDR: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: drives mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB: drives reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WR: drives mem_write=1, i_or_d=1. Waits for mem_ready, then goes to FETCH.
- EXEC_R: drives alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- EXEC_I: drives alu_src_a=1, alu_src_b=10, alu_op=00. Goes to I_WB.
- I_WB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- BRANCH: drives alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Goes to FETCH.
- JUMP: drives pc_write=1, pc_source=10. Goes to FETCH.
- ILLEGAL: illegal_op=1 and every other control is 0. Stays in ILLEGAL until reset.
- instr_done is asserted in MEM_WB, R_WB, I_WB, BRANCH and JUMP. It is asserted in MEM_WR only in the cycle mem_ready=1.
- instr_count increments on the edge ending each instr_done cycle and wraps modulo 2^CNT_W.
- Latency with mem_ready tied to 1: R=4, lw=5, sw=4, addi=4, beq=3, j=3 cycles. Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds 1.
- mem_ready is ignored in all states other than FETCH, MEM_RD and MEM_WR.
- Strobes are never asserted together: mem_read and mem_write, and ir_write and reg_write, are never high in the same cycle.
- instr_op is sampled only in DECODE and MEM_ADDR. Changes in other states have no effect.
- rst_n low mid-instruction, including during a stretched memory wait: immediate return to S_RESET with all strobes 0. No partial write is completed.
- State and counter registers are updated with nonblocking assignments. Output logic is purely combinational from state, instr_op and mem_ready.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the 4-bit state enum (S_RESET=0, S_FETCH=1, then the remaining states);
  - ALU_OP_ADD/SUB/FUNCT, ALUB_* and PCSRC_* constants.
- No sub-module needed. The next-state logic, output decode and counter live in one module.

Test Plan:
- Reset release, mem_ready=1, instr_op=000000 -> states FETCH, DECODE, EXEC_R, R_WB. reg_write=1 and reg_dst=1 in cycle 4. instr_done pulses once. instr_count goes 0 to 1.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD -> 7-cycle instruction. mem_read=1 and i_or_d=1 held in MEM_RD. mem_to_reg=1 in MEM_WB.
- sw (101011), mem_ready low for 1 cycle -> mem_write=1 for 2 cycles. reg_write never asserted. instr_done coincides with mem_ready=1.
- beq (000100), then j (000010) -> 3 cycles each. pc_write_cond=1 with pc_source=01, then pc_write=1 with pc_source=10. instr_count increments by 2.
- instr_op=111111 in DECODE -> ILLEGAL, illegal_op=1, all strobes 0 for 20 cycles. rst_n low -> state 0 and illegal_op=0.
- rst_n asserted mid-FETCH wait, and CNT_W=4 over 16 instructions -> outputs drop to 0 asynchronously. Counter wraps 15 to 0.
